// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode and funct3 constants shared by the core and its ALU
package riscv_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] OPIMM   = 7'b0010011;
    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] MISCMEM = 7'b0001111;
    localparam logic [6:0] SYSTEM  = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational RV32I integer ALU for OP and OP-IMM instructions
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);
    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    // funct7[5] means SUB only for register ops; ADDI reuses that bit as immediate
    always_comb begin
        o_result = 32'd0;
        case (i_funct3)
            F3_ADD:  o_result = (i_op == OP && i_funct7_5) ? (i_a - i_b) : (i_a + i_b);
            F3_SLL:  o_result = i_a << w_shamt;
            F3_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            F3_SLTU: o_result = {31'd0, i_a < i_b};
            F3_XOR:  o_result = i_a ^ i_b;
            F3_SR:   o_result = i_funct7_5 ? $unsigned($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
            F3_OR:   o_result = i_a | i_b;
            F3_AND:  o_result = i_a & i_b;
        endcase
    end

endmodule

// File: rtl/riscv_core.sv
// rtl/riscv_core.sv - single-issue RV32I core with separate fetch and load/store ports
module riscv_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        res,
    input  logic        halt,
    input  logic [31:0] in_data,
    output logic [31:0] in_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [31:0] address,
    output logic        write_e,
    output logic        read_e,
    output logic [3:0]  BE
);
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_regs [0:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val, w_alu_b, w_alu_res, w_pc4;
    logic [31:0] w_nxpc, w_wdata, w_load;
    logic        w_wb, w_is_load, w_is_store, w_taken;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;
    logic [3:0]  w_be;

    assign w_opcode = in_data[6:0];
    assign w_rd     = in_data[11:7];
    assign w_funct3 = in_data[14:12];
    assign w_rs1    = in_data[19:15];
    assign w_rs2    = in_data[24:20];
    assign w_imm_i  = {{20{in_data[31]}}, in_data[31:20]};
    assign w_imm_s  = {{20{in_data[31]}}, in_data[31:25], in_data[11:7]};
    assign w_imm_b  = {{19{in_data[31]}}, in_data[31], in_data[7], in_data[30:25], in_data[11:8], 1'b0};
    assign w_imm_u  = {in_data[31:12], 12'd0};
    assign w_imm_j  = {{11{in_data[31]}}, in_data[31], in_data[19:12], in_data[20], in_data[30:21], 1'b0};

    assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_alu_b    = (w_opcode == OP) ? w_rs2_val : w_imm_i;
    assign w_pc4      = r_pc + 32'd4;
    assign w_is_load  = r_valid && (w_opcode == LOAD);
    assign w_is_store = r_valid && (w_opcode == STORE);
    // Load/store address doubles as the JALR target (rs1 + immI)
    assign address    = w_rs1_val + ((w_opcode == STORE) ? w_imm_s : w_imm_i);

    riscv_alu u_alu (
        .i_op       (w_opcode),
        .i_funct3   (w_funct3),
        .i_funct7_5 (in_data[30]),
        .i_a        (w_rs1_val),
        .i_b        (w_alu_b),
        .o_result   (w_alu_res)
    );

    always_comb begin
        case (w_funct3)
            F3_BEQ:  w_taken = (w_rs1_val == w_rs2_val);
            F3_BNE:  w_taken = (w_rs1_val != w_rs2_val);
            F3_BLT:  w_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            F3_BGE:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            F3_BLTU: w_taken = (w_rs1_val < w_rs2_val);
            F3_BGEU: w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (address[1:0])
            2'd0:    w_lbyte = data_in[7:0];
            2'd1:    w_lbyte = data_in[15:8];
            2'd2:    w_lbyte = data_in[23:16];
            default: w_lbyte = data_in[31:24];
        endcase
    end

    assign w_lhalf = address[1] ? data_in[31:16] : data_in[15:0];

    always_comb begin
        case (w_funct3)
            F3_B:    w_load = {{24{w_lbyte[7]}}, w_lbyte};
            F3_H:    w_load = {{16{w_lhalf[15]}}, w_lhalf};
            F3_BU:   w_load = {24'd0, w_lbyte};
            F3_HU:   w_load = {16'd0, w_lhalf};
            F3_W:    w_load = data_in;
            default: w_load = data_in;
        endcase
    end

    always_comb begin
        case (w_funct3[1:0])
            2'b00:   w_be = 4'b0001 << address[1:0];
            2'b01:   w_be = address[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign BE      = (w_is_load || w_is_store) ? w_be : 4'b0000;
    assign read_e  = w_is_load;
    assign write_e = w_is_store;

    always_comb begin
        data_out = 32'd0;
        if (w_is_store) begin
            case (w_funct3)
                F3_B:    data_out = {4{w_rs2_val[7:0]}};
                F3_H:    data_out = {2{w_rs2_val[15:0]}};
                default: data_out = w_rs2_val;
            endcase
        end
    end

    // A bubble (r_valid low) holds the PC so the first real fetch is RESET_PC
    always_comb begin
        w_nxpc  = w_pc4;
        w_wb    = 1'b0;
        w_wdata = 32'd0;
        if (!r_valid) begin
            w_nxpc = r_pc;
        end else begin
            case (w_opcode)
                LUI:    begin w_wb = 1'b1; w_wdata = w_imm_u; end
                AUIPC:  begin w_wb = 1'b1; w_wdata = r_pc + w_imm_u; end
                JAL:    begin w_wb = 1'b1; w_wdata = w_pc4; w_nxpc = r_pc + w_imm_j; end
                JALR:   begin w_wb = 1'b1; w_wdata = w_pc4; w_nxpc = address & 32'hFFFF_FFFE; end
                BRANCH: if (w_taken) w_nxpc = r_pc + w_imm_b;
                LOAD:   begin w_wb = 1'b1; w_wdata = w_load; end
                OP, OPIMM: begin w_wb = 1'b1; w_wdata = w_alu_res; end
                STORE, MISCMEM, SYSTEM: ;
                default: ;
            endcase
        end
    end

    assign in_addr = halt ? r_pc : w_nxpc;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else if (!halt) begin
            r_pc    <= w_nxpc;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wb && !halt && (w_rd != 5'd0))
            r_regs[w_rd] <= w_wdata;
    end

endmodule

// File: tb/tb_riscv_core.sv
// tb/tb_riscv_core.sv - directed and randomized self-checking bench for riscv_core
module tb_riscv_core;

    typedef enum int {
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_LUI, M_AUIPC, M_JAL, M_JALR, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
        M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW, M_FENCE, M_ECALL, M_NUM
    } mn_t;

    logic        clk = 1'b0;
    logic        res, halt;
    logic [31:0] in_data, data_in, in_addr, data_out, address;
    logic        write_e, read_e;
    logic [3:0]  BE;

    riscv_core dut (
        .clk(clk), .res(res), .halt(halt), .in_data(in_data), .in_addr(in_addr),
        .data_in(data_in), .data_out(data_out), .address(address),
        .write_e(write_e), .read_e(read_e), .BE(BE)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_x [0:31];
    logic [31:0] m_pc;
    logic [31:0] obs_in_addr, obs_addr, obs_dout;
    logic [3:0]  obs_be;
    logic        obs_we, obs_re;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(mn_t mn, int rd, int rs1, int rs2, logic [31:0] imm);
        logic [4:0] d, s1, s2;
        d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
        case (mn)
            M_ADD:   return {7'h00, s2, s1, 3'd0, d, 7'h33};
            M_SUB:   return {7'h20, s2, s1, 3'd0, d, 7'h33};
            M_SLL:   return {7'h00, s2, s1, 3'd1, d, 7'h33};
            M_SLT:   return {7'h00, s2, s1, 3'd2, d, 7'h33};
            M_SLTU:  return {7'h00, s2, s1, 3'd3, d, 7'h33};
            M_XOR:   return {7'h00, s2, s1, 3'd4, d, 7'h33};
            M_SRL:   return {7'h00, s2, s1, 3'd5, d, 7'h33};
            M_SRA:   return {7'h20, s2, s1, 3'd5, d, 7'h33};
            M_OR:    return {7'h00, s2, s1, 3'd6, d, 7'h33};
            M_AND:   return {7'h00, s2, s1, 3'd7, d, 7'h33};
            M_ADDI:  return {imm[11:0], s1, 3'd0, d, 7'h13};
            M_SLTI:  return {imm[11:0], s1, 3'd2, d, 7'h13};
            M_SLTIU: return {imm[11:0], s1, 3'd3, d, 7'h13};
            M_XORI:  return {imm[11:0], s1, 3'd4, d, 7'h13};
            M_ORI:   return {imm[11:0], s1, 3'd6, d, 7'h13};
            M_ANDI:  return {imm[11:0], s1, 3'd7, d, 7'h13};
            M_SLLI:  return {7'h00, imm[4:0], s1, 3'd1, d, 7'h13};
            M_SRLI:  return {7'h00, imm[4:0], s1, 3'd5, d, 7'h13};
            M_SRAI:  return {7'h20, imm[4:0], s1, 3'd5, d, 7'h13};
            M_LUI:   return {imm[31:12], d, 7'h37};
            M_AUIPC: return {imm[31:12], d, 7'h17};
            M_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'h6F};
            M_JALR:  return {imm[11:0], s1, 3'd0, d, 7'h67};
            M_BEQ:   return {imm[12], imm[10:5], s2, s1, 3'd0, imm[4:1], imm[11], 7'h63};
            M_BNE:   return {imm[12], imm[10:5], s2, s1, 3'd1, imm[4:1], imm[11], 7'h63};
            M_BLT:   return {imm[12], imm[10:5], s2, s1, 3'd4, imm[4:1], imm[11], 7'h63};
            M_BGE:   return {imm[12], imm[10:5], s2, s1, 3'd5, imm[4:1], imm[11], 7'h63};
            M_BLTU:  return {imm[12], imm[10:5], s2, s1, 3'd6, imm[4:1], imm[11], 7'h63};
            M_BGEU:  return {imm[12], imm[10:5], s2, s1, 3'd7, imm[4:1], imm[11], 7'h63};
            M_LB:    return {imm[11:0], s1, 3'd0, d, 7'h03};
            M_LH:    return {imm[11:0], s1, 3'd1, d, 7'h03};
            M_LW:    return {imm[11:0], s1, 3'd2, d, 7'h03};
            M_LBU:   return {imm[11:0], s1, 3'd4, d, 7'h03};
            M_LHU:   return {imm[11:0], s1, 3'd5, d, 7'h03};
            M_SB:    return {imm[11:5], s2, s1, 3'd0, imm[4:0], 7'h23};
            M_SH:    return {imm[11:5], s2, s1, 3'd1, imm[4:0], 7'h23};
            M_SW:    return {imm[11:5], s2, s1, 3'd2, imm[4:0], 7'h23};
            M_FENCE: return 32'h0FF0_000F;
            default: return 32'h0000_0073;
        endcase
    endfunction

    function automatic logic [31:0] rnd_imm(mn_t mn);
        logic [31:0] r;
        r = $urandom;
        case (mn)
            M_SLLI, M_SRLI, M_SRAI: return {27'd0, r[4:0]};
            M_LUI, M_AUIPC:         return {r[31:12], 12'd0};
            M_JAL:                  return {{11{r[20]}}, r[20:1], 1'b0};
            M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU:
                                    return {{19{r[12]}}, r[12:1], 1'b0};
            default:                return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    // One instruction cycle: present the word for the model PC, check outputs, then retire in the model
    task automatic step(input mn_t mn, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input logic [31:0] dmem, input bit hold);
        logic [31:0] a, b, ea, nx, v, dout, lb, lh;
        logic        wr, re, we, tk;
        logic [3:0]  be;
        a = m_x[rs1]; b = m_x[rs2]; ea = a + imm; nx = m_pc + 32'd4;
        v = 32'd0; dout = 32'd0; be = 4'd0; tk = 1'b0;
        lb = (dmem >> (32'(ea[1:0]) * 8)) & 32'hFF;
        lh = (dmem >> (32'(ea[1]) * 16)) & 32'hFFFF;
        re = mn inside {M_LB, M_LH, M_LW, M_LBU, M_LHU};
        we = mn inside {M_SB, M_SH, M_SW};
        wr = !(we || mn inside {M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU, M_FENCE, M_ECALL});
        case (mn)
            M_ADD:   v = a + b;
            M_SUB:   v = a - b;
            M_SLL:   v = a << b[4:0];
            M_SLT:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            M_SLTU:  v = (a < b) ? 32'd1 : 32'd0;
            M_XOR:   v = a ^ b;
            M_SRL:   v = a >> b[4:0];
            M_SRA:   v = $signed(a) >>> b[4:0];
            M_OR:    v = a | b;
            M_AND:   v = a & b;
            M_ADDI:  v = a + imm;
            M_SLTI:  v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            M_SLTIU: v = (a < imm) ? 32'd1 : 32'd0;
            M_XORI:  v = a ^ imm;
            M_ORI:   v = a | imm;
            M_ANDI:  v = a & imm;
            M_SLLI:  v = a << imm[4:0];
            M_SRLI:  v = a >> imm[4:0];
            M_SRAI:  v = $signed(a) >>> imm[4:0];
            M_LUI:   v = imm;
            M_AUIPC: v = m_pc + imm;
            M_JAL:   begin v = m_pc + 32'd4; nx = m_pc + imm; end
            M_JALR:  begin v = m_pc + 32'd4; nx = ea & 32'hFFFF_FFFE; end
            M_BEQ:   tk = (a == b);
            M_BNE:   tk = (a != b);
            M_BLT:   tk = ($signed(a) < $signed(b));
            M_BGE:   tk = ($signed(a) >= $signed(b));
            M_BLTU:  tk = (a < b);
            M_BGEU:  tk = (a >= b);
            M_LB:    v = (lb >= 32'd128) ? lb - 32'd256 : lb;
            M_LH:    v = (lh >= 32'd32768) ? lh - 32'd65536 : lh;
            M_LW:    v = dmem;
            M_LBU:   v = lb;
            M_LHU:   v = lh;
            M_SB:    dout = (b & 32'hFF) * 32'h0101_0101;
            M_SH:    dout = (b & 32'hFFFF) * 32'h0001_0001;
            M_SW:    dout = b;
            default: ;
        endcase
        if (tk) nx = m_pc + imm;
        if (mn inside {M_LB, M_LBU, M_SB}) be = 4'b0001 << ea[1:0];
        else if (mn inside {M_LH, M_LHU, M_SH}) be = ea[1] ? 4'b1100 : 4'b0011;
        else if (mn inside {M_LW, M_SW}) be = 4'b1111;

        @(negedge clk);
        in_data = enc(mn, rd, rs1, rs2, imm);
        halt    = hold;
        data_in = hold ? $urandom : dmem;
        #1;
        obs_in_addr = in_addr; obs_addr = address; obs_dout = data_out;
        obs_be = BE; obs_we = write_e; obs_re = read_e;
        check($sformatf("%s in_addr", mn.name()), in_addr, hold ? m_pc : nx);
        check($sformatf("%s write_e", mn.name()), {31'd0, write_e}, {31'd0, we});
        check($sformatf("%s read_e", mn.name()), {31'd0, read_e}, {31'd0, re});
        check($sformatf("%s BE", mn.name()), {28'd0, BE}, {28'd0, be});
        if (re || we) check($sformatf("%s address", mn.name()), address, ea);
        if (we) check($sformatf("%s data_out", mn.name()), data_out, dout);
        if (!hold) begin
            if (wr && rd != 0) m_x[rd] = v;
            m_pc = nx;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_addr"}, in_addr, 32'h0);
        check({tag, " write_e"}, {31'd0, write_e}, 32'd0);
        check({tag, " read_e"}, {31'd0, read_e}, 32'd0);
        check({tag, " BE"}, {28'd0, BE}, 32'd0);
    endtask

    initial begin
        logic [31:0] p;
        mn_t mn;
        int rd, rs1, rs2;
        logic [31:0] imm, dm;

        foreach (m_x[i]) m_x[i] = 32'hx;
        m_x[0] = 32'd0;
        res = 1'b1; halt = 1'b0; in_data = 32'd0; data_in = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        check("reset data_out", data_out, 32'h0);

        // Bubble: a store word on in_data must not strobe
        @(negedge clk);
        res = 1'b0;
        in_data = enc(M_SW, 0, 0, 0, 32'd0);
        #1;
        check_idle("bubble");
        m_pc = 32'h0;

        step(M_ADDI, 1, 0, 0, 32'd5, 32'd0, 0);
        check("first in_addr", obs_in_addr, 32'h4);
        step(M_ADDI, 2, 1, 0, -32'sd3, 32'd0, 0);
        check("second in_addr", obs_in_addr, 32'h8);
        step(M_SW, 0, 0, 2, 32'd0, 32'd0, 0);
        check("x2 value", obs_dout, 32'd2);

        step(M_ADDI, 1, 0, 0, 32'h80, 32'd0, 0);
        step(M_LUI, 2, 0, 0, 32'h1234_5000, 32'd0, 0);
        step(M_ADDI, 2, 2, 0, 32'h678, 32'd0, 0);
        step(M_SB, 0, 1, 2, 32'd1, 32'd0, 0);
        check("sb address", obs_addr, 32'h81);
        check("sb BE", {28'd0, obs_be}, 32'h2);
        check("sb data_out", obs_dout, 32'h7878_7878);
        check("sb write_e", {31'd0, obs_we}, 32'd1);
        step(M_LB, 3, 1, 0, 32'd1, 32'h0000_8000, 0);
        step(M_LBU, 4, 1, 0, 32'd1, 32'h0000_8000, 0);
        step(M_SW, 0, 0, 3, 32'd0, 32'd0, 0);
        check("lb value", obs_dout, 32'hFFFF_FF80);
        step(M_SW, 0, 0, 4, 32'd0, 32'd0, 0);
        check("lbu value", obs_dout, 32'h0000_0080);

        p = m_pc;
        repeat (2) begin
            step(M_LW, 5, 1, 0, 32'd0, 32'hCAFE_F00D, 1);
            check("halt in_addr", obs_in_addr, p);
            check("halt address", obs_addr, 32'h80);
            check("halt read_e", {31'd0, obs_re}, 32'd1);
        end
        step(M_LW, 5, 1, 0, 32'd0, 32'hCAFE_F00D, 0);
        check("unhalt in_addr", obs_in_addr, p + 32'd4);
        repeat (2) step(M_ADDI, 5, 5, 0, 32'd1, 32'd0, 1);
        step(M_ADDI, 5, 5, 0, 32'd1, 32'd0, 0);
        step(M_SW, 0, 0, 5, 32'd0, 32'd0, 0);
        check("halt no writeback", obs_dout, 32'hCAFE_F00E);

        step(M_JALR, 0, 0, 0, 32'h20, 32'd0, 0);
        step(M_BNE, 0, 1, 2, 32'd16, 32'd0, 0);
        check("bne target", obs_in_addr, 32'h30);
        step(M_ADDI, 5, 0, 0, 32'h101, 32'd0, 0);
        step(M_JALR, 1, 5, 0, 32'd8, 32'd0, 0);
        check("jalr target", obs_in_addr, 32'h108);
        step(M_SW, 0, 0, 1, 32'd0, 32'd0, 0);
        check("jalr link", obs_dout, 32'h38);

        step(M_LUI, 6, 0, 0, 32'h8000_0000, 32'd0, 0);
        step(M_SRAI, 7, 6, 0, 32'd31, 32'd0, 0);
        step(M_ADDI, 8, 0, 0, 32'hFFFF_FFFF, 32'd0, 0);
        step(M_SLTU, 9, 0, 8, 32'd0, 32'd0, 0);
        step(M_SLT, 10, 8, 0, 32'd0, 32'd0, 0);
        step(M_ADDI, 0, 0, 0, 32'd5, 32'd0, 0);
        step(M_SW, 0, 0, 7, 32'd0, 32'd0, 0);
        check("srai 31", obs_dout, 32'hFFFF_FFFF);
        step(M_SW, 0, 0, 9, 32'd0, 32'd0, 0);
        check("sltu -1", obs_dout, 32'd1);
        step(M_SW, 0, 0, 10, 32'd0, 32'd0, 0);
        check("slt -1 0", obs_dout, 32'd1);
        step(M_SW, 0, 0, 0, 32'd0, 32'd0, 0);
        check("x0 zero", obs_dout, 32'd0);

        for (int r = 1; r < 32; r++) begin
            step(M_LUI, r, 0, 0, rnd_imm(M_LUI), 32'd0, 0);
            step(M_ADDI, r, r, 0, rnd_imm(M_ADDI), 32'd0, 0);
        end
        for (int k = 0; k < 300; k++) begin
            mn  = mn_t'($urandom_range(0, int'(M_NUM) - 1));
            rd  = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            rs2 = $urandom_range(0, 31);
            imm = rnd_imm(mn);
            dm  = $urandom;
            if ($urandom_range(0, 7) == 0) step(mn, rd, rs1, rs2, imm, dm, 1);
            step(mn, rd, rs1, rs2, imm, dm, 0);
        end
        for (int r = 0; r < 32; r++) step(M_SW, 0, 0, r, 32'd0, 32'd0, 0);

        // Asynchronous reset in the middle of a store cycle
        @(negedge clk);
        in_data = enc(M_SW, 0, 0, 1, 32'd0);
        halt = 1'b0;
        #1;
        check("pre-reset write_e", {31'd0, write_e}, 32'd1);
        #1;
        res = 1'b1;
        #1;
        check_idle("async reset");
        check("async reset data_out", data_out, 32'h0);
        @(negedge clk);
        res = 1'b0;
        #1;
        check_idle("bubble2");
        m_pc = 32'h0;
        step(M_ADDI, 11, 0, 0, 32'd7, 32'd0, 0);
        check("post-reset in_addr", obs_in_addr, 32'h4);
        step(M_SW, 0, 0, 11, 32'd0, 32'd0, 0);
        check("post-reset x11", obs_dout, 32'd7);
        step(M_SW, 0, 0, 12, 32'd0, 32'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_core.md
Name: riscv_core

Overview:
- Single-issue RV32I integer core with Harvard buses: an instruction-fetch port and a separate load/store data port.
- Instantiated inside the SoC top level next to a synchronous instruction ROM, a byte-writable data RAM and an IO decoder; the top level also drives the wait-state (halt) logic.
- Each unstalled clock executes one instruction. The next fetch address is computed combinationally, so no branch flush is needed.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- res  in  1  asynchronous active-high reset.
- halt  in  1  stall request from memory system; freezes all architectural state.
- in_data  in  32  instruction word for the address presented on in_addr at the previous edge.
- in_addr  out  32  instruction fetch address (word-aligned).
- data_in  in  32  load data word (aligned word containing address); valid in the cycle halt is low.
- data_out  out  32  store data, replicated or shifted onto byte lanes.
- address  out  32  data address = rs1 + imm (full 32 bits; bit 31 selects IO in the SoC).
- write_e  out  1  store strobe.
- read_e  out  1  load strobe.
- BE  out  4  byte enables for the current access; 0 when no access.

Behaviour:
- Reset (res high, asynchronous): PC <= RESET_PC and valid flag <= 0.
  - in_addr = RESET_PC; write_e = 0; read_e = 0; BE = 0; data_out = 0.
  - Register file contents are not reset, except x0 which always reads 0.
- First cycle after reset is a bubble (valid = 0): no execution, in_addr = RESET_PC, valid <= 1.
- Instruction timing: the instruction in in_data belongs to PC, the register captured at the last edge. in_addr = halt ? PC : NXPC, and at an unstalled edge PC <= NXPC.
- NXPC:
  - PC+4 by default.
  - JAL: PC+immJ.
  - JALR: (rs1+immI) with bit 0 cleared.
  - Taken branch: PC+immB.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: signed or unsigned compare as per ISA.
- ALU: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and the immediate forms. Shift amount is the low 5 bits. LUI; AUIPC = PC+immU. JAL/JALR write PC+4 to rd.
- Loads (LB/LH/LW/LBU/LHU):
  - read_e = 1 combinationally while a load is in execute.
  - BE = 0001<<addr[1:0] for byte, 0011<<(addr[1]*2) for half, 1111 for word.
  - Writeback happens at the first edge with halt low. The result is extracted from data_in by addr[1:0] and sign- or zero-extended.
- Stores (SB/SH/SW):
  - write_e = 1 and BE as for loads.
  - data_out: byte replicated to all 4 lanes, half replicated to both halves, word as-is.
  - Misaligned accesses are not trapped; the low address bits select lanes as above.
- halt high: no PC, regfile or valid update. read_e/write_e/address/BE/data_out stay stable, because in_data is held via in_addr=PC.
- Writes to rd=x0 are discarded.
- FENCE, ECALL, EBREAK, CSR and unknown opcodes execute as NOP (PC+4).
- A register read in the same cycle as a write to that register returns the old value. Writeback occurs at the edge, and the next instruction sees the new value.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISCMEM, SYSTEM.
  - funct3 constants for branch, load/store and ALU.
  - RESET_PC default.
- One sub-module: riscv_alu, a combinational ALU taking op, funct3, funct7[5], a and b.
- Register file, decode, branch logic and load/store alignment stay in riscv_core.

Test Plan:
- Reset, then release with ROM[0]=ADDI x1,x0,5 and ROM[1]=ADDI x2,x1,-3 -> in_addr sequence 0,0,4,8; x2=2.
- Store/load: x1=0x80, x2=0x12345678, SB x2,1(x1) -> address=0x81, BE=0010, data_out=0x78787878, write_e=1. Then LB x3,1(x1) with data_in=0x0000_8000 -> x3=0xFFFFFF80; LBU -> 0x00000080.
- Halt: assert halt for 2 cycles during a LW -> in_addr, address and read_e held, no writeback. Deassert halt -> rd <= data_in, PC advances by 4.
- Branch/jump: BNE x1,x2,+16 at PC=0x20 with x1!=x2 -> in_addr=0x30 in the same cycle. JALR x1,8(x5) with x5=0x101 -> in_addr=0x108, x1=PC+4.
- ALU edge cases: SRA of 0x80000000 by 31 -> 0xFFFFFFFF; SLTU x,-1 -> 1; SLT -1,0 -> 1; ADDI to x0 -> x0 stays 0.
- Asynchronous reset asserted mid-store -> write_e, read_e and BE drop to 0 immediately; in_addr=RESET_PC.
